fetch_sequencer: RTL and testbench

//  Instruction-fetch controller for the byte-addressed, big-endian instruction memory.

---
 rtl/fetch_sequencer.sv | 109 ++++++++++
 tb/tb_fetch_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: holds the PC, reads the combinational IM, queues
// {pc, instr} pairs and hands them to decode over a valid/ready handshake.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned IM_BYTES = 256,
  parameter int unsigned QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  // Handshake: a word transfers on any rising edge where out_valid & out_ready are
  // both 1; out_valid never depends on out_ready, and out_* stay stable until taken.

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);
  localparam logic [PW:0] ONE  = (PW+1)'(1);
  localparam logic [31:0] LAST_PC = 32'(IM_BYTES - 4);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [31:0]   mem_pc    [QDEPTH];
  logic [31:0]   mem_instr [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
  logic [PW:0]   count;
  logic          push, pop, pc_legal, tgt_legal;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= LAST_PC);
  endfunction

  always_comb begin
    pc_legal   = legal(pc);
    tgt_legal  = legal(redirect_pc);
    pop        = (count != '0) && out_ready;
    push       = (state == RUN) && fetch_en && pc_legal &&
                 ((count != FULL) || pop) && !redirect_valid;
    rd_ptr_inc = rd_ptr + 1'b1;
    state_nxt  = state;
    pc_nxt     = pc;
    if (redirect_valid) begin
      state_nxt = tgt_legal ? RUN : FAULT;
      pc_nxt    = redirect_pc;
    end else begin
      if ((state == RUN) && !pc_legal) state_nxt = FAULT;
      if (push) pc_nxt = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      pc        <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr_inc;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
        // Output registers track the next head; they hold when the queue empties.
        if (push && ((count == '0) || (pop && (count == ONE)))) begin
          out_instr <= im_instr;
          out_pc    <= pc;
        end else if (pop && (count > ONE)) begin
          out_instr <= mem_instr[rd_ptr_inc];
          out_pc    <= mem_pc[rd_ptr_inc];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= im_instr;
    end
  end

  assign im_addr   = pc;
  assign out_valid = (count != '0);
  assign fault     = (state == FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: queue-based reference model of the fetch rules,
// directed scenarios plus a randomized redirect/backpressure run.
module tb_fetch_sequencer;

  localparam int QDEPTH = 2;
  localparam int IM_BYTES = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] im_addr, im_instr, out_instr, out_pc, redirect_pc;
  logic        fetch_en, redirect_valid, out_valid, out_ready, fault;

  logic [7:0]  im_mem [256];
  logic [63:0] exp_q [$];
  logic [31:0] got_q [$];
  logic [63:0] last_head;
  logic [31:0] m_pc;
  bit          m_fault;
  int          total = 0;
  int          bad = 0;

  fetch_sequencer #(.RESET_PC(32'h0), .IM_BYTES(IM_BYTES), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .im_addr(im_addr), .im_instr(im_instr),
    .fetch_en(fetch_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault)
  );

  always #5 clk = ~clk;

  assign im_instr = (im_addr <= 32'd252) ?
    {im_mem[im_addr[7:0]], im_mem[im_addr[7:0] + 8'd1],
     im_mem[im_addr[7:0] + 8'd2], im_mem[im_addr[7:0] + 8'd3]} : 32'hDEAD_BEEF;

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'(IM_BYTES - 4));
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a > 32'd252) return 32'hDEAD_BEEF;
    return {im_mem[a[7:0]], im_mem[a[7:0] + 8'd1], im_mem[a[7:0] + 8'd2], im_mem[a[7:0] + 8'd3]};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc = 32'h0;
    m_fault = 1'b0;
    last_head = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  // Advance one clock; the model applies the fetch rules to the inputs seen before the edge.
  task automatic step();
    bit pop, push;
    logic [63:0] w;
    pop  = (exp_q.size() != 0) && out_ready;
    push = !m_fault && fetch_en && legal(m_pc) && ((exp_q.size() < QDEPTH) || pop) && !redirect_valid;
    w = {m_pc, word_at(m_pc)};
    if (out_valid && out_ready) got_q.push_back(out_pc);
    @(posedge clk);
    if (redirect_valid) begin
      exp_q.delete();
      m_pc = redirect_pc;
      m_fault = !legal(redirect_pc);
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(w);
        m_pc = m_pc + 32'd4;
      end else if (!m_fault && !legal(m_pc)) begin
        m_fault = 1'b1;
      end
    end
    if (exp_q.size() != 0) last_head = exp_q[0];
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    #12;
    total++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || fault !== 1'b0 || im_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_state v=%b pc=%h ins=%h flt=%b addr=%h required 0/0/0/0/0", out_valid, out_pc, out_instr, fault, im_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    step();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'h0011_2233) begin
      bad++;
      $display("FAIL seq_word0 v=%b pc=%h ins=%h required 1/00000000/00112233", out_valid, out_pc, out_instr);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h4 || out_instr !== 32'h4455_6677) begin
      bad++;
      $display("FAIL seq_word1 v=%b pc=%h ins=%h required 1/00000004/44556677", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    repeat (6) step();
    total++;
    if (im_addr !== 32'h8 || out_valid !== 1'b1 || out_pc !== 32'h0) begin
      bad++;
      $display("FAIL bp_full addr=%h v=%b pc=%h required 00000008/1/00000000", im_addr, out_valid, out_pc);
    end
    got_q.delete();
    out_ready = 1'b1;
    repeat (3) begin
      step();
      total++;
      if (out_valid !== (exp_q.size() != 0) || out_pc !== last_head[63:32] || out_instr !== last_head[31:0] || im_addr !== m_pc) begin
        bad++;
        $display("FAIL bp_model v=%b/%b pc=%h/%h ins=%h/%h addr=%h/%h", out_valid, exp_q.size() != 0, out_pc, last_head[63:32], out_instr, last_head[31:0], im_addr, m_pc);
      end
    end
    total++;
    if (got_q.size() != 3 || got_q[0] !== 32'h0 || got_q[1] !== 32'h4 || got_q[2] !== 32'h8) begin
      bad++;
      $display("FAIL bp_order n=%0d first=%h,%h,%h required 3 words 0,4,8", got_q.size(), got_q.size() > 0 ? got_q[0] : 32'hx, got_q.size() > 1 ? got_q[1] : 32'hx, got_q.size() > 2 ? got_q[2] : 32'hx);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    repeat (3) step();
    got_q.delete();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || im_addr !== 32'h40) begin
      bad++;
      $display("FAIL redir_flush v=%b addr=%h required 0/00000040", out_valid, im_addr);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== word_at(32'h40)) begin
      bad++;
      $display("FAIL redir_first v=%b pc=%h ins=%h required 1/00000040/%h", out_valid, out_pc, out_instr, word_at(32'h40));
    end
    step();
    total++;
    if (got_q.size() != 2 || got_q[0] !== 32'h0 || got_q[1] !== 32'h40) begin
      bad++;
      $display("FAIL redir_stale n=%0d got=%h,%h required 2 words 0,40", got_q.size(), got_q.size() > 0 ? got_q[0] : 32'hx, got_q.size() > 1 ? got_q[1] : 32'hx);
    end
  endtask

  task automatic test_end_of_mem();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hF0;
    step();
    redirect_valid = 1'b0;
    got_q.delete();
    repeat (8) begin
      step();
      total++;
      if (out_valid !== (exp_q.size() != 0) || out_pc !== last_head[63:32] || im_addr !== m_pc || fault !== m_fault) begin
        bad++;
        $display("FAIL eom_model v=%b/%b pc=%h/%h addr=%h/%h flt=%b/%b", out_valid, exp_q.size() != 0, out_pc, last_head[63:32], im_addr, m_pc, fault, m_fault);
      end
    end
    total++;
    if (fault !== 1'b1 || im_addr !== 32'h100 || out_valid !== 1'b0 || got_q.size() != 4 || got_q[got_q.size()-1] !== 32'hFC) begin
      bad++;
      $display("FAIL eom_fault flt=%b addr=%h v=%b n=%0d required 1/00000100/0/4 words ending FC", fault, im_addr, out_valid, got_q.size());
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    total++;
    if (fault !== 1'b0 || im_addr !== 32'h10) begin
      bad++;
      $display("FAIL eom_recover flt=%b addr=%h required 0/00000010", fault, im_addr);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10) begin
      bad++;
      $display("FAIL eom_resume v=%b pc=%h required 1/00000010", out_valid, out_pc);
    end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1;
    redirect_pc = 32'h22;
    step();
    redirect_valid = 1'b0;
    repeat (4) begin
      total++;
      if (fault !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL misaligned flt=%b v=%b required 1/0", fault, out_valid);
      end
      step();
    end
  endtask

  task automatic test_fetch_en_and_reset();
    logic [31:0] frozen;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    frozen = im_addr;
    fetch_en = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    total++;
    if (im_addr !== 32'h8 || frozen !== 32'h8 || out_valid !== 1'b0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL fetch_en_off addr=%h frozen=%h v=%b flt=%b required 8/8/0/0", im_addr, frozen, out_valid, fault);
    end
    fetch_en = 1'b1;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || im_addr !== 32'h0 || fault !== 1'b0) begin
      bad++;
      $display("FAIL async_reset v=%b addr=%h flt=%b required 0/00000000/0", out_valid, im_addr, fault);
    end
    do_reset();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      fetch_en = ($urandom_range(0, 7) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 19);
      if (r < 14) redirect_pc = 32'($urandom_range(0, 63)) * 32'd4;
      else if (r < 17) redirect_pc = 32'h100 + 32'($urandom_range(0, 63)) * 32'd4;
      else redirect_pc = 32'($urandom_range(0, 255));
      step();
      total++;
      if (out_valid !== (exp_q.size() != 0) || out_pc !== last_head[63:32] || out_instr !== last_head[31:0] || im_addr !== m_pc || fault !== m_fault) begin
        bad++;
        $display("FAIL rand_model i=%0d v=%b/%b pc=%h/%h ins=%h/%h addr=%h/%h flt=%b/%b", i, out_valid, exp_q.size() != 0, out_pc, last_head[63:32], out_instr, last_head[31:0], im_addr, m_pc, fault, m_fault);
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) im_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) im_mem[i] = 8'(i * 8'h11);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_end_of_mem();
    test_misaligned();
    test_fetch_en_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
